// File: rtl/fib_rr_scheduler_if.sv
// Requester and engine signal bundle for fib_rr_scheduler.
// The scheduler takes the slave view; whatever drives the requesters and the engine takes the master view.
interface fib_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IW   = 5,
  parameter int FW   = 20
);
  logic [NREQ-1:0]    req;
  logic [NREQ*IW-1:0] req_idx;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [FW-1:0]      rsp_data;
  logic               rsp_err;
  logic               eng_start;
  logic [IW-1:0]      eng_i;
  logic               eng_ready;
  logic               eng_done_tick;
  logic [FW-1:0]      eng_f;

  modport slave (
    input  req, req_idx, rsp_ready, eng_ready, eng_done_tick, eng_f,
    output gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_i
  );

  modport master (
    output req, req_idx, rsp_ready, eng_ready, eng_done_tick, eng_f,
    input  gnt, rsp_valid, rsp_data, rsp_err, eng_start, eng_i
  );
endinterface

// File: rtl/fib_rr_scheduler.sv
// Round-robin scheduler sharing one Fibonacci engine among NREQ requesters,
// with a per-transaction engine timeout and a valid/ready response per requester.
module fib_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IW   = 5,
  parameter int FW   = 20,
  parameter int TMO  = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  fib_rr_scheduler_if.slave  bus,
  output logic               busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [LW-1:0]   last_q;
  logic [LW-1:0]   owner_q;
  logic [IW-1:0]   idx_q;
  logic [FW-1:0]   data_q;
  logic            err_q;
  logic [TW-1:0]   tmo_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            start_q;
  logic            busy_q;

  logic            win_vld_d;
  logic [LW-1:0]   win_d;
  logic [IW-1:0]   win_idx_d;
  logic [IW-1:0]   idx_arr [NREQ];

  function automatic logic [NREQ-1:0] onehot(input logic [LW-1:0] k);
    return {{(NREQ-1){1'b0}}, 1'b1} << k;
  endfunction

  // Search starts just after the last served requester, so the last one has lowest priority.
  always_comb begin
    logic [LW-1:0] k;
    k         = '0;
    win_vld_d = 1'b0;
    win_d     = '0;
    win_idx_d = '0;
    for (int n = 0; n < NREQ; n++) begin
      idx_arr[n] = bus.req_idx[n*IW +: IW];
    end
    for (int j = 1; j <= NREQ; j++) begin
      k = LW'((int'(last_q) + j) % NREQ);
      if (!win_vld_d && bus.req[k]) begin
        win_vld_d = 1'b1;
        win_d     = k;
        win_idx_d = idx_arr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= LW'(NREQ - 1);
      owner_q     <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q   <= '0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d && bus.eng_ready) begin
            owner_q <= win_d;
            idx_q   <= win_idx_d;
            gnt_q   <= onehot(win_d);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A completion in the final timeout cycle still wins over the timeout.
          if (bus.eng_done_tick) begin
            data_q      <= bus.eng_f;
            err_q       <= 1'b0;
            rsp_valid_q <= onehot(owner_q);
            state_q     <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            data_q      <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= onehot(owner_q);
            state_q     <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            last_q      <= owner_q;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.eng_start = start_q;
  assign bus.eng_i     = start_q ? idx_q : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = (|rsp_valid_q) ? data_q : '0;
  assign bus.rsp_err   = (|rsp_valid_q) & err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fib_rr_scheduler.sv
// Bench for fib_rr_scheduler: behavioural engine, counted requesters, and a
// queue scoreboard predicting grant order and responses from round-robin rules.
module tb_fib_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IW   = 5;
  localparam int FW   = 20;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  fib_rr_scheduler_if #(.NREQ(NREQ), .IW(IW), .FW(FW)) bus ();

  fib_rr_scheduler #(.NREQ(NREQ), .IW(IW), .FW(FW), .TMO(TMO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int owner; int idx; } gexp_t;
  typedef struct { int owner; int data; int err; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gnt_seen = 0;
  int gnt_cyc  = 0;
  int rise_cyc = 0;
  int m_last   = NREQ - 1;

  int            cnt      [NREQ];
  logic [IW-1:0] ridx     [NREQ];
  int            plan_cnt [NREQ];
  logic [IW-1:0] plan_idx [NREQ];

  bit hang = 0, inj_done = 0, release_eng = 0, bp_hold = 0;
  int force_lat = -1;

  function automatic logic [NREQ-1:0] oh(input int k);
    return NREQ'(1) << k;
  endfunction

  function automatic int fib(input int i);
    int a = 0, b = 1, t;
    repeat (i) begin
      t = (a + b) % (1 << FW);
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected order: repeatedly pick the first requester with work left after the last one served.
  task automatic plan_round(input int err);
    int c [NREQ];
    int total = 0;
    gexp_t g;
    rexp_t r;
    for (int k = 0; k < NREQ; k++) begin
      c[k] = plan_cnt[k];
      total += c[k];
    end
    repeat (total) begin
      int w = -1;
      for (int j = 1; j <= NREQ; j++) begin
        int k = (m_last + j) % NREQ;
        if (w < 0 && c[k] > 0) w = k;
      end
      c[w]--;
      m_last  = w;
      g.owner = w;
      g.idx   = int'(plan_idx[w]);
      gq.push_back(g);
      r.owner = w;
      r.data  = (err != 0) ? 0 : fib(int'(plan_idx[w]));
      r.err   = err;
      rq.push_back(r);
    end
    for (int k = 0; k < NREQ; k++) begin
      ridx[k] = plan_idx[k];
      cnt[k]  = plan_cnt[k];
    end
  endtask

  task automatic set_plan(input int c0, c1, c2, c3, input int i0, i1, i2, i3);
    plan_cnt[0] = c0; plan_cnt[1] = c1; plan_cnt[2] = c2; plan_cnt[3] = c3;
    plan_idx[0] = IW'(i0); plan_idx[1] = IW'(i1); plan_idx[2] = IW'(i2); plan_idx[3] = IW'(i3);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(gq.size() == 0 && rq.size() == 0 && !busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 64'(n < 4000), 64'(1));
    @(posedge clk);
    #2;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: level held while work remains; each grant consumes one unit.
  initial begin
    logic [NREQ-1:0]    r, prev;
    logic [NREQ*IW-1:0] pk;
    prev = '0;
    for (int k = 0; k < NREQ; k++) begin
      cnt[k] = 0;
      ridx[k] = '0;
    end
    bus.req = '0;
    bus.req_idx = '0;
    bus.rsp_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      r  = '0;
      pk = '0;
      for (int k = 0; k < NREQ; k++) begin
        if ((bus.gnt & oh(k)) != '0 && cnt[k] > 0) cnt[k]--;
        if (cnt[k] > 0) r = r | oh(k);
        pk = pk | ((NREQ*IW)'(ridx[k]) << (k*IW));
      end
      if (prev == '0 && r != '0) rise_cyc = cyc;
      prev = r;
      bus.req = r;
      bus.req_idx = pk;
      bus.rsp_ready = bp_hold ? '0 : NREQ'($urandom);
    end
  end

  // Engine model: random completion latency, optional hang, injectable stray done_tick.
  initial begin
    bit e_busy = 0;
    int e_cnt = 0, e_f = 0;
    bus.eng_ready = 1'b1;
    bus.eng_done_tick = 1'b0;
    bus.eng_f = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_done_tick = 1'b0;
      bus.eng_f = '0;
      if (!reset_n) begin
        e_busy = 0;
        bus.eng_ready = 1'b1;
      end else if (bus.eng_start) begin
        e_busy = 1;
        bus.eng_ready = 1'b0;
        e_f = fib(int'(bus.eng_i));
        e_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(12, 0));
      end else if (inj_done) begin
        inj_done = 0;
        bus.eng_done_tick = 1'b1;
        bus.eng_f = FW'(999);
      end else if (release_eng) begin
        release_eng = 0;
        e_busy = 0;
        bus.eng_ready = 1'b1;
      end else if (e_busy && !hang) begin
        if (e_cnt == 0) begin
          bus.eng_done_tick = 1'b1;
          bus.eng_f = FW'(e_f);
          bus.eng_ready = 1'b1;
          e_busy = 0;
        end else begin
          e_cnt--;
        end
      end
    end
  end

  // Monitor: pops grant and response expectations as the DUT presents them.
  initial begin
    bit pv = 0, pacc = 0;
    logic [NREQ-1:0] p_valid = '0;
    logic [FW-1:0] p_data = '0;
    logic p_err = 1'b0;
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv = 0;
      end else begin
        if (bus.gnt != '0) begin
          gnt_seen++;
          gnt_cyc = cyc;
          if (gq.size() == 0) begin
            check("gnt_unexpected", 64'(bus.gnt), 64'(0));
          end else begin
            g = gq.pop_front();
            check("gnt_owner", 64'(bus.gnt), 64'(oh(g.owner)));
            check("eng_start_with_gnt", 64'(bus.eng_start), 64'(1));
            check("eng_i", 64'(bus.eng_i), 64'(g.idx));
          end
        end
        if (!bus.eng_start) check("eng_i_zero_idle", 64'(bus.eng_i), 64'(0));
        if (bus.rsp_valid != '0) begin
          check("no_gnt_during_rsp", 64'(bus.gnt), 64'(0));
          if (pv && !pacc) begin
            check("rsp_valid_stable", 64'(bus.rsp_valid), 64'(p_valid));
            check("rsp_data_stable", 64'(bus.rsp_data), 64'(p_data));
            check("rsp_err_stable", 64'(bus.rsp_err), 64'(p_err));
          end else if (rq.size() == 0) begin
            check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
          end else begin
            r = rq.pop_front();
            check("rsp_owner", 64'(bus.rsp_valid), 64'(oh(r.owner)));
            check("rsp_data", 64'(bus.rsp_data), 64'(r.data));
            check("rsp_err", 64'(bus.rsp_err), 64'(r.err));
            if (r.err != 0) check("tmo_latency", 64'(cyc - gnt_cyc), 64'(TMO + 1));
          end
          pv = 1;
          p_valid = bus.rsp_valid;
          p_data = bus.rsp_data;
          p_err = bus.rsp_err;
          pacc = (bus.rsp_valid & bus.rsp_ready) != '0;
        end else begin
          if (pv && !pacc) check("rsp_valid_held", 64'(bus.rsp_valid), 64'(p_valid));
          pv = 0;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
    check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_eng_start"}, 64'(bus.eng_start), 64'(0));
    check({tag, "_eng_i"}, 64'(bus.eng_i), 64'(0));
  endtask

  initial begin
    int g0, n;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    // All four held from reset, two transactions each: order 0,1,2,3,0,1,2,3.
    set_plan(2, 2, 2, 2, 0, 1, 25, 30);
    plan_round(0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle("contention");

    set_plan(1, 0, 0, 0, 10, 0, 0, 0);
    plan_round(0);
    wait_idle("single");
    check("gnt_latency", 64'(gnt_cyc - rise_cyc), 64'(1));

    set_plan(0, 0, 1, 0, 0, 0, 3, 0);
    plan_round(0);
    wait_idle("rot_a");
    set_plan(1, 1, 0, 1, 4, 6, 0, 8);
    plan_round(0);
    wait_idle("rot_b");

    set_plan(0, 1, 0, 0, 0, 31, 0, 0);
    plan_round(0);
    wait_idle("wrap");

    // Completion lands in the same cycle the timeout would fire.
    force_lat = TMO - 1;
    set_plan(1, 0, 0, 0, 20, 0, 0, 0);
    plan_round(0);
    wait_idle("done_vs_tmo");
    force_lat = -1;

    hang = 1;
    set_plan(0, 0, 1, 0, 0, 0, 7, 0);
    plan_round(1);
    wait_idle("timeout");
    set_plan(0, 1, 0, 0, 0, 5, 0, 0);
    plan_round(0);
    g0 = gnt_seen;
    repeat (30) @(negedge clk);
    check("no_gnt_engine_hung", 64'(gnt_seen), 64'(g0));
    check("idle_engine_hung", 64'(busy), 64'(0));
    inj_done = 1;
    repeat (5) @(negedge clk);
    check("late_done_ignored_busy", 64'(busy), 64'(0));
    check("late_done_ignored_gnt", 64'(gnt_seen), 64'(g0));
    hang = 0;
    release_eng = 1;
    wait_idle("after_hang");

    bp_hold = 1;
    set_plan(0, 1, 1, 0, 0, 12, 15, 0);
    plan_round(0);
    n = 0;
    while (bus.rsp_valid == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 64'(n < 200), 64'(1));
    g0 = gnt_seen;
    repeat (20) @(negedge clk);
    check("bp_no_gnt", 64'(gnt_seen), 64'(g0));
    bp_hold = 0;
    wait_idle("backpressure");

    // Reset while the engine is stuck in WAIT.
    hang = 1;
    set_plan(0, 1, 1, 1, 0, 9, 11, 13);
    plan_round(0);
    g0 = gnt_seen;
    n = 0;
    while (gnt_seen == g0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_gnt_seen", 64'(n < 200), 64'(1));
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    gq.delete();
    rq.delete();
    for (int k = 0; k < NREQ; k++) cnt[k] = 0;
    hang = 0;
    m_last = NREQ - 1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    set_plan(1, 1, 1, 1, 2, 3, 4, 5);
    plan_round(0);
    wait_idle("after_reset");

    for (int r = 0; r < 25; r++) begin
      int mask = int'($urandom_range(15, 1));
      for (int k = 0; k < NREQ; k++) begin
        plan_cnt[k] = ((mask >> k) & 1) != 0 ? int'($urandom_range(3, 1)) : 0;
        plan_idx[k] = IW'($urandom_range(31, 0));
      end
      plan_round(0);
      wait_idle("random");
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_checks - n_fail, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
